// File: rtl/lmul_sequencer.sv
// LMUL multi-cycle controller: radix-2 shift-and-add multiply over WIDTH cycles,
// stalling fetch while running, then a single register-file write strobe.
module lmul_sequencer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  input  logic [ADDR_W-1:0]    iDestination,
  output logic                 oStall,
  output logic                 oBusy,
  output logic                 oWriteEnable,
  output logic [ADDR_W-1:0]    oWriteAddress,
  output logic [2*WIDTH-1:0]   oResult,
  output logic [WIDTH-1:0]     oResultHigh
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_add;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic [ADDR_W-1:0]    dest;

  assign acc_add = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_nxt    = state;
    oStall       = 1'b0;
    oBusy        = 1'b1;
    oWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        oBusy  = 1'b0;
        oStall = iStart;
        if (iStart) state_nxt = RUN;
      end
      RUN: begin
        oStall = 1'b1;
        if (cnt == LAST) state_nxt = WRITE;
      end
      WRITE: begin
        oWriteEnable = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      cnt           <= '0;
      dest          <= '0;
      oResult       <= '0;
      oResultHigh   <= '0;
      oWriteAddress <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (iStart) begin
          mcand  <= {{WIDTH{1'b0}}, iA};
          mplier <= iB;
          dest   <= iDestination;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Final iteration: publish the product so it is stable for the WRITE cycle.
          if (cnt == LAST) begin
            oResult       <= acc_add;
            oResultHigh   <= acc_add[2*WIDTH-1:WIDTH];
            oWriteAddress <= dest;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lmul_sequencer.sv
// Directed bench for lmul_sequencer: a cycle-count model built on a*b checks
// every cycle, and per-operation literal expectations pin the model.
module tb_lmul_sequencer;
  localparam int WIDTH = 16;
  localparam int ADDR_W = 8;

  logic Clock = 1'b0, Reset = 1'b0, iStart = 1'b0;
  logic [WIDTH-1:0] iA = '0, iB = '0;
  logic [ADDR_W-1:0] iDestination = '0;
  logic oStall, oBusy, oWriteEnable;
  logic [ADDR_W-1:0] oWriteAddress;
  logic [2*WIDTH-1:0] oResult;
  logic [WIDTH-1:0] oResultHigh;

  lmul_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
    .iDestination(iDestination), .oStall(oStall), .oBusy(oBusy),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oResult(oResult), .oResultHigh(oResultHigh));

  always #5 Clock = ~Clock;

  int checks = 0, fails = 0;
  int stall_cnt = 0, we_cnt = 0;
  bit count_stall = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: an operation is just "product a*b lands WIDTH edges after capture".
  bit m_active = 0;
  int m_k = 0;
  logic [2*WIDTH-1:0] m_prod = '0, m_res = '0;
  logic [ADDR_W-1:0] m_dest = '0, m_addr = '0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_active = 0; m_k = 0; m_res = '0; m_addr = '0;
    end else if (!m_active) begin
      if (iStart) begin
        m_active = 1; m_k = 0;
        m_prod = (2*WIDTH)'(iA) * (2*WIDTH)'(iB);
        m_dest = iDestination;
      end
    end else begin
      m_k++;
      if (m_k == WIDTH) begin m_res = m_prod; m_addr = m_dest; end
      if (m_k == WIDTH + 1) m_active = 0;
    end
  end

  always @(negedge Clock) begin
    chk("busy", oBusy, m_active);
    chk("we", oWriteEnable, m_active && m_k == WIDTH);
    chk("stall", oStall, m_active ? (m_k < WIDTH) : iStart);
    chk("result", oResult, m_res);
    chk("result_high", oResultHigh, m_res[2*WIDTH-1:WIDTH]);
    chk("waddr", oWriteAddress, m_addr);
    if (count_stall && oStall) stall_cnt++;
    if (oWriteEnable) we_cnt++;
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  // Launch one LMUL and wait for its write; optionally keep iStart held and
  // scramble the operands mid-RUN.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic [ADDR_W-1:0] d, input logic [31:0] lit,
                    input bit hold, input bit scramble);
    int n;
    iA = a; iB = b; iDestination = d; iStart = 1'b1;
    tick();
    if (!hold) iStart = 1'b0;
    n = 0;
    while (!oWriteEnable && n < 40) begin
      tick(); n++;
      if (scramble && n == 7) begin iA = ~a; iB = b ^ 16'h5A5A; iDestination = ~d; end
    end
    chk("latency", 64'(n), 64'(WIDTH));
    chk("lit_result", oResult, lit);
    chk("lit_high", oResultHigh, lit[31:16]);
    chk("lit_addr", oWriteAddress, d);
    tick();
    chk("idle_after_write", oBusy, 1'b0);
  endtask

  initial begin
    int w0;
    #23;
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_we", oWriteEnable, 1'b0);
    chk("rst_result", oResult, 32'h0);
    chk("rst_addr", oWriteAddress, 8'h0);
    @(posedge Clock); #1 Reset = 1'b1;
    tick();

    // 1: basic 8*5, stall length
    count_stall = 1;
    op(16'd8, 16'd5, 8'd1, 32'd40, 0, 0);
    count_stall = 0;
    chk("stall_cycles", 64'(stall_cnt), 64'd17);

    // 2, 3: wide operands, all-ones, zero multiplier
    op(16'd21896, 16'd64677, 8'd1, 32'h546900A8, 0, 0);
    op(16'hFFFF, 16'hFFFF, 8'd3, 32'hFFFE0001, 0, 0);
    op(16'h1234, 16'h0, 8'd4, 32'h0, 0, 0);

    // 4: iStart held with operands changed mid-RUN, then restart in first IDLE cycle
    w0 = we_cnt;
    op(16'd300, 16'd200, 8'd9, 32'd60000, 1, 1);
    chk("held_one_write", 64'(we_cnt - w0), 64'd1);
    op(16'd12, 16'd13, 8'd10, 32'd156, 0, 0);
    chk("held_second_write", 64'(we_cnt - w0), 64'd2);

    // 5: reset at RUN cycle 7
    w0 = we_cnt;
    iA = 16'd100; iB = 16'd100; iDestination = 8'd7; iStart = 1'b1;
    tick(); iStart = 1'b0;
    repeat (7) tick();
    Reset = 1'b0; #1;
    chk("abort_busy", oBusy, 1'b0);
    chk("abort_stall", oStall, 1'b0);
    chk("abort_we", oWriteEnable, 1'b0);
    chk("abort_result", oResult, 32'h0);
    chk("abort_high", oResultHigh, 16'h0);
    chk("abort_addr", oWriteAddress, 8'h0);
    iStart = 1'b1; #1;
    chk("abort_stall_follows_start", oStall, 1'b1);
    iStart = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    repeat (20) tick();
    chk("abort_no_write", 64'(we_cnt - w0), 64'd0);
    op(16'd3, 16'd7, 8'd2, 32'd21, 0, 0);

    // 6: back-to-back, second uses first's destination and result
    op(16'd5, 16'd9, 8'd1, 32'd45, 0, 0);
    op(16'd45, 16'd11, 8'd1, 32'd495, 0, 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
